// File: rtl/pc_gen_if.sv
// Fetch-stage PC generator interface.
// master: drives stall/redirect/trap/RAS hints and observes the PC outputs.
// slave : the pc_gen side; consumes the controls and drives the PC outputs.
//   stall, redirect_valid/target, trap_valid/vector, ras_push, ras_pop  (master -> slave)
//   pc_dout, pc_next, misalign, redirect_pending, ras_empty              (slave -> master)
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] pc_dout;
    logic [XLEN-1:0] pc_next;
    logic            misalign;
    logic            redirect_pending;
    logic            ras_empty;

    modport master (
        output stall,
        output redirect_valid,
        output redirect_target,
        output trap_valid,
        output trap_vector,
        output ras_push,
        output ras_pop,
        input  pc_dout,
        input  pc_next,
        input  misalign,
        input  redirect_pending,
        input  ras_empty
    );

    modport slave (
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  trap_valid,
        input  trap_vector,
        input  ras_push,
        input  ras_pop,
        output pc_dout,
        output pc_next,
        output misalign,
        output redirect_pending,
        output ras_empty
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Holds the current PC and picks the next one by fixed priority:
// trap > unstalled redirect > released pending redirect > stall hold >
// RAS-predicted return > sequential increment. Redirects seen during a stall
// are parked and applied once the stall drops. A small circular return
// address stack supplies return predictions.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - pc_gen_if.slave: control inputs and PC/status outputs
//          (pc_dout registered; pc_next, misalign, ras_empty decoded from state)
module pc_gen #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     ALIGN_BITS   = 2,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);

    localparam int unsigned     PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned     CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] INC   = XLEN'(1) << ALIGN_BITS;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    // Parameter sanity: circular pointer arithmetic relies on a power-of-2 depth.
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_gen: RAS_DEPTH must be a power of 2 and at least 2");
    end
    if (ALIGN_BITS < 1 || ALIGN_BITS >= XLEN) begin : g_bad_align
        $error("pc_gen: ALIGN_BITS must be in 1..XLEN-1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             pend_q;
    logic             pend_d;
    logic [XLEN-1:0]  pend_tgt_q;
    logic [XLEN-1:0]  pend_tgt_d;

    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q;
    logic [PTR_W-1:0] ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q;
    logic [CNT_W-1:0] ras_cnt_d;

    // ------------------------------------------------------------------
    // Derived values
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  pc_inc;
    logic [PTR_W-1:0] ras_top_idx;
    logic [XLEN-1:0]  ras_top;
    logic             ras_is_empty;

    assign pc_inc       = pc_q + INC;
    assign ras_top_idx  = ras_ptr_q - PTR_W'(1);
    assign ras_top      = ras_mem[ras_top_idx];
    assign ras_is_empty = (ras_cnt_q == '0);

    // ------------------------------------------------------------------
    // Next-PC select and pending-redirect tracking
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_inc;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;

        if (bus.trap_valid) begin
            // Trap wins even over a stall and drops any parked redirect.
            pc_d   = bus.trap_vector;
            pend_d = 1'b0;
        end else if (bus.redirect_valid && !bus.stall) begin
            pc_d   = bus.redirect_target;
            pend_d = 1'b0;
        end else if (pend_q && !bus.stall) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
        end else if (bus.stall) begin
            pc_d = pc_q;
            // Latest redirect seen during the stall is the one that counts.
            if (bus.redirect_valid) begin
                pend_d     = 1'b1;
                pend_tgt_d = bus.redirect_target;
            end
        end else if (bus.ras_pop && !ras_is_empty) begin
            pc_d = ras_top;
        end
    end

    // ------------------------------------------------------------------
    // RAS control: only moves when the PC advances on a non-trap path
    // ------------------------------------------------------------------
    logic             ras_en;
    logic             do_push;
    logic             do_pop;
    logic             ras_we;
    logic [PTR_W-1:0] ras_wr_idx;

    always_comb begin
        ras_en     = !bus.stall && !bus.trap_valid;
        do_push    = ras_en && bus.ras_push;
        do_pop     = ras_en && bus.ras_pop && !ras_is_empty;
        ras_we     = 1'b0;
        ras_wr_idx = ras_ptr_q;
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;

        if (do_push && do_pop) begin
            // Return followed immediately by a call: replace the top in place.
            ras_we     = 1'b1;
            ras_wr_idx = ras_top_idx;
        end else if (do_push) begin
            // When full the write lands on the oldest entry, overwriting it.
            ras_we     = 1'b1;
            ras_wr_idx = ras_ptr_q;
            ras_ptr_d  = ras_ptr_q + PTR_W'(1);
            ras_cnt_d  = (ras_cnt_q == CNT_FULL) ? ras_cnt_q : ras_cnt_q + CNT_W'(1);
        end else if (do_pop) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            ras_ptr_q  <= '0;
            ras_cnt_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            ras_ptr_q  <= ras_ptr_d;
            ras_cnt_q  <= ras_cnt_d;
        end
    end

    // RAS storage; cleared on reset so reads never see unknowns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else if (ras_we) begin
            ras_mem[ras_wr_idx] <= pc_inc;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_dout          = pc_q;
    assign bus.pc_next          = pc_d;
    assign bus.misalign         = |pc_q[ALIGN_BITS-1:0];
    assign bus.redirect_pending = pend_q;
    assign bus.ras_empty        = ras_is_empty;

endmodule
